// File: rtl/dec288_bitmap.sv
// dec288_bitmap: index-to-one-hot decoder driving a 288-bit set/clear/toggle bitmap.
// Optional registered find-first-one on the map when DEC288_FFO_EN is defined.
module dec288_bitmap #(
    parameter int WID   = 288,
    parameter int IW    = 9,
    parameter int NONE  = 511,
    parameter int CHUNK = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [IW-1:0]  req_idx,
    input  logic           clr_all,
    output logic           busy,
    output logic [WID-1:0] onehot,
    output logic [WID-1:0] map,
    output logic           ack,
    output logic           err,
    output logic [IW-1:0]  first_set
);

    localparam int NCHUNK = WID / CHUNK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLR   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] clr_cnt;
    logic       clr_last;
    logic       clr_step;
    logic       accept;
    logic       in_range;
    logic       s1_valid;
    logic       s1_in;
    logic [1:0] s1_op;

    assign accept   = req_valid & req_ready;
    assign in_range = req_idx < IW'(WID);
    assign clr_last = clr_cnt == 4'(NCHUNK - 1);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: drain the single in-flight stage, then sweep the chunks
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clr_all)   state_nxt = DRAIN;
            DRAIN:   if (!s1_valid) state_nxt = CLR;
            CLR:     if (clr_last)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // FSM outputs: ready only when idle and no clear is being requested
    always_comb begin
        req_ready = (state == IDLE) & ~clr_all;
        busy      = state != IDLE;
        clr_step  = state == CLR;
    end

    // Chunk counter for the clear sweep, parked at zero outside CLR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        clr_cnt <= '0;
        else if (clr_step) clr_cnt <= clr_last ? 4'd0 : clr_cnt + 4'd1;
        else               clr_cnt <= '0;
    end

    // Stage 1: capture op and range flag; decode in-range indices into onehot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_in    <= 1'b0;
            s1_op    <= 2'b00;
            onehot   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_in <= in_range;
                s1_op <= req_op;
                if (in_range)
                    onehot <= {{(WID-1){1'b0}}, 1'b1} << req_idx;
            end
        end
    end

    // Stage 2: retire into the map (or clear one chunk) and pulse ack/err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map <= '0;
            ack <= 1'b0;
            err <= 1'b0;
        end else begin
            ack <= s1_valid;
            err <= s1_valid & ~s1_in;
            if (clr_step) begin
                for (int k = 0; k < NCHUNK; k++)
                    if (clr_cnt == 4'(k))
                        map[k*CHUNK +: CHUNK] <= '0;
            end else if (s1_valid && s1_in) begin
                unique case (s1_op)
                    2'b00: map <= map;
                    2'b01: map <= map | onehot;
                    2'b10: map <= map & ~onehot;
                    2'b11: map <= map ^ onehot;
                endcase
            end
        end
    end

`ifdef DEC288_FFO_EN
    logic [IW-1:0] ffo;

    // Highest set bit of the map, NONE when empty
    always_comb begin
        ffo = IW'(NONE);
        for (int i = 0; i < WID; i++)
            if (map[i]) ffo = IW'(i);
    end

    // Register the encoder result; one cycle behind the map
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) first_set <= IW'(NONE);
        else        first_set <= ffo;
    end
`else
    assign first_set = IW'(NONE);
`endif

endmodule

// File: tb/tb_dec288_bitmap.sv
// tb_dec288_bitmap: directed scenarios plus random traffic against a
// transaction-level model of the bitmap (queue of retirements, clear timeline).
module tb_dec288_bitmap;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_valid = 1'b0;
    logic [1:0]   req_op = 2'b00;
    logic [8:0]   req_idx = 9'd0;
    logic         clr_all = 1'b0;
    logic         req_ready;
    logic         busy;
    logic [287:0] onehot;
    logic [287:0] map;
    logic         ack;
    logic         err;
    logic [8:0]   first_set;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dec288_bitmap dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_idx(req_idx),
        .clr_all(clr_all), .busy(busy),
        .onehot(onehot), .map(map),
        .ack(ack), .err(err), .first_set(first_set)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0] op;
        logic [8:0] idx;
        longint     due;
    } req_t;

    req_t         pend[$];
    logic [287:0] m_map = '0;
    logic [287:0] m_onehot = '0;
    logic         m_ack = 1'b0;
    logic         m_err = 1'b0;
    logic [8:0]   m_fs = 9'd511;
    logic         m_busy = 1'b0;
    int           clr_age = 0;
    longint       cyc = 0;

    function automatic logic [8:0] hi_bit(input logic [287:0] v);
        for (int i = 287; i >= 0; i--)
            if (v[i]) return 9'(i);
        return 9'd511;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_map = '0; m_onehot = '0; m_ack = 0; m_err = 0;
            m_fs = 9'd511; m_busy = 0; clr_age = 0;
            pend.delete();
        end else begin
            req_t r;
`ifdef DEC288_FFO_EN
            m_fs = hi_bit(m_map);
`endif
            cyc++;
            m_ack = 0; m_err = 0;
            while (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                m_ack = 1;
                if (r.idx >= 9'd288) m_err = 1;
                else case (r.op)
                    2'b01: m_map[r.idx] = 1'b1;
                    2'b10: m_map[r.idx] = 1'b0;
                    2'b11: m_map[r.idx] = ~m_map[r.idx];
                    default: ;
                endcase
            end
            if (m_busy) begin
                clr_age++;
                if (clr_age >= 2) m_map[(clr_age-2)*32 +: 32] = '0;
                if (clr_age == 10) m_busy = 0;
            end else if (clr_all) begin
                m_busy = 1; clr_age = 0;
            end else if (req_valid) begin
                pend.push_back('{req_op, req_idx, cyc + 1});
                if (req_idx < 9'd288) begin
                    m_onehot = '0;
                    m_onehot[req_idx] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [287:0] act,
                         input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        check("map", map, m_map);
        check("onehot", onehot, m_onehot);
        check("ack", 288'(ack), 288'(m_ack));
        check("err", 288'(err), 288'(m_err));
        check("busy", 288'(busy), 288'(m_busy));
        check("ready", 288'(req_ready), 288'(!m_busy && !clr_all));
        check("first_set", 288'(first_set), 288'(m_fs));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [8:0] idx, input logic c);
        @(posedge clk); #2;
        req_valid = v; req_op = op; req_idx = idx; clr_all = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'b00, 9'd0, 0);
    endtask

    logic [287:0] lit;
    logic [287:0] save_map;
    int           nb;

    initial begin
        #1 rst_n = 1'b0;
        #20;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_map", map, 288'd0);
        check("rst_fs", 288'(first_set), 288'd511);

        // reset with ops in flight
        drive(1, 2'b01, 9'd50, 0);
        drive(1, 2'b01, 9'd60, 0);
        #1 rst_n = 1'b0;
        req_valid = 0;
        #3;
        check("t1_map", map, 288'd0);
        check("t1_onehot", onehot, 288'd0);
        check("t1_ack", 288'(ack), 288'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_noack", 288'(ack), 288'd0);
        end

        // toggle 287 twice, clear 5 on empty map
        drive(1, 2'b11, 9'd287, 0);
        drive(1, 2'b11, 9'd287, 0);
        drive(0, 2'b00, 9'd0, 0);
        @(negedge clk);
        check("t3_bit1", 288'(map[287]), 288'd1);
        drive(0, 2'b00, 9'd0, 0);
        @(negedge clk);
        check("t3_bit0", 288'(map[287]), 288'd0);
        drive(1, 2'b10, 9'd5, 0);
        idle(2);
        @(negedge clk);
        check("t3_clr_ack", 288'(ack), 288'd1);
        check("t3_clr_map", map, 288'd0);

        // set 0,143,144,287 back to back
        drive(1, 2'b01, 9'd0, 0);
        drive(1, 2'b01, 9'd143, 0);
        drive(1, 2'b01, 9'd144, 0);
        drive(1, 2'b01, 9'd287, 0);
        idle(3);
        @(negedge clk);
        lit = '0;
        lit[0] = 1; lit[143] = 1; lit[144] = 1; lit[287] = 1;
        check("t2_map", map, lit);

        // out of range indices
        save_map = map;
        drive(1, 2'b01, 9'd288, 0);
        drive(1, 2'b01, 9'd511, 0);
        drive(0, 2'b00, 9'd0, 0);
        @(negedge clk);
        check("t4_ack", 288'(ack), 288'd1);
        check("t4_err", 288'(err), 288'd1);
        drive(0, 2'b00, 9'd0, 0);
        @(negedge clk);
        check("t4_err2", 288'(err), 288'd1);
        check("t4_map", map, save_map);
        lit = '0; lit[287] = 1;
        check("t4_onehot", onehot, lit);

        // set 10 then clr_all together with a request
        drive(1, 2'b01, 9'd10, 0);
        drive(1, 2'b01, 9'd20, 1);
        @(negedge clk);
        check("t5_ready", 288'(req_ready), 288'd0);
        drive(0, 2'b00, 9'd0, 0);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) check("t5_ack10", 288'(ack), 288'd1);
            if (busy) nb++;
            else break;
        end
        check("t5_busy_len", 288'(nb), 288'd10);
        check("t5_map", map, 288'd0);
        check("t5_ready2", 288'(req_ready), 288'd1);
        lit = '0; lit[10] = 1;
        check("t5_onehot", onehot, lit);

`ifdef DEC288_FFO_EN
        drive(1, 2'b01, 9'd3, 0);   idle(3); @(negedge clk);
        check("t6_fs3", 288'(first_set), 288'd3);
        drive(1, 2'b01, 9'd200, 0); idle(3); @(negedge clk);
        check("t6_fs200", 288'(first_set), 288'd200);
        drive(1, 2'b10, 9'd200, 0); idle(3); @(negedge clk);
        check("t6_fs3b", 288'(first_set), 288'd3);
        drive(1, 2'b10, 9'd3, 0);   idle(3); @(negedge clk);
        check("t6_fs511", 288'(first_set), 288'd511);
`else
        drive(1, 2'b01, 9'd3, 0); idle(3); @(negedge clk);
        check("t6_fs_tied", 288'(first_set), 288'd511);
`endif

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] ix;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 75)      ix = 9'($urandom_range(0, 287));
            else if (sel < 90) ix = 9'($urandom_range(288, 510));
            else               ix = 9'd511;
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ix,
                  $urandom_range(0, 99) < 3);
            if (n == 1500) begin
                #1 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        idle(15);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
